// File: rtl/plot_shadow_fb_if.sv
// Plot-bus and read/clear handshake bundle for the shadow framebuffer.
// The master drives the plot bus and requests; the framebuffer is the slave.
interface plot_shadow_fb_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       rd_req;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_ready;
  logic       rd_valid;
  logic [2:0] rd_colour;
  logic       clr_req;
  logic       clr_busy;
  logic       oor;

  modport master (
    output plot, x, y, colour, rd_req, rd_x, rd_y, clr_req,
    input  rd_ready, rd_valid, rd_colour, clr_busy, oor
  );

  modport slave (
    input  plot, x, y, colour, rd_req, rd_x, rd_y, clr_req,
    output rd_ready, rd_valid, rd_colour, clr_busy, oor
  );
endinterface

// File: rtl/plot_shadow_fb.sv
// Shadow copy of the 160x120x3 framebuffer: mirrors plots into a single-port RAM,
// serves pixel reads over a ready/valid handshake and provides a hardware clear.
module plot_shadow_fb #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 19200
) (
  input  logic            clk,
  input  logic            resetn,
  plot_shadow_fb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD_PEND, S_RD_DATA, S_CLEAR} state_t;

  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    pix_addr = {1'b0, py, 7'b0000000} + {3'b000, py, 5'b00000} + {7'b0000000, px};
  endfunction

  function automatic logic in_range(input logic [7:0] px, input logic [6:0] py);
    in_range = (px < 8'(WIDTH)) && (py < 7'(HEIGHT));
  endfunction

  logic [2:0]  mem [0:DEPTH-1];

  state_t      state_r, state_next_s;
  logic [14:0] clr_cnt_r;
  logic [14:0] rd_addr_r;
  logic        rd_oor_r;
  logic        rd_ready_r, rd_valid_r, clr_busy_r, oor_r;
  logic [2:0]  rd_colour_r;

  logic        plot_ok_s, rd_accept_s, rd_issue_s, clr_write_s, wr_en_s;
  logic [14:0] wr_addr_s;
  logic [2:0]  wr_data_s;

  // Port arbitration: an in-range plot always wins; reads and clear writes only use idle slots.
  always_comb begin
    plot_ok_s   = bus.plot && in_range(bus.x, bus.y);
    rd_accept_s = (state_r == S_IDLE) && !bus.clr_req && bus.rd_req;
    rd_issue_s  = (state_r == S_RD_PEND) && !bus.plot;
    clr_write_s = (state_r == S_CLEAR) && !bus.plot;
    wr_en_s     = plot_ok_s || clr_write_s;
    if (plot_ok_s) begin
      wr_addr_s = pix_addr(bus.x, bus.y);
      wr_data_s = bus.colour;
    end else begin
      wr_addr_s = clr_cnt_r;
      wr_data_s = 3'b000;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.clr_req) state_next_s = S_CLEAR;
        else if (bus.rd_req) state_next_s = S_RD_PEND;
        else state_next_s = S_IDLE;
      end
      S_RD_PEND: begin
        if (!bus.plot) state_next_s = S_RD_DATA;
        else state_next_s = S_RD_PEND;
      end
      S_RD_DATA: state_next_s = S_IDLE;
      S_CLEAR: begin
        if (clr_write_s && (clr_cnt_r == LAST_ADDR)) state_next_s = S_IDLE;
        else state_next_s = S_CLEAR;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= S_IDLE;
    else         state_r <= state_next_s;
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wr_addr_s] <= wr_data_s;
  end

  // Clear counter and captured read address.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clr_cnt_r <= 15'd0;
      rd_addr_r <= 15'd0;
      rd_oor_r  <= 1'b0;
    end else begin
      if (clr_write_s) begin
        if (clr_cnt_r == LAST_ADDR) clr_cnt_r <= 15'd0;
        else                        clr_cnt_r <= clr_cnt_r + 15'd1;
      end
      if (rd_accept_s) begin
        rd_addr_r <= pix_addr(bus.rd_x, bus.rd_y);
        rd_oor_r  <= !in_range(bus.rd_x, bus.rd_y);
      end
    end
  end

  // Registered outputs; the RAM read register doubles as rd_colour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ready_r  <= 1'b1;
      rd_valid_r  <= 1'b0;
      rd_colour_r <= 3'b000;
      clr_busy_r  <= 1'b0;
      oor_r       <= 1'b0;
    end else begin
      rd_ready_r <= (state_next_s == S_IDLE);
      clr_busy_r <= (state_next_s == S_CLEAR);
      rd_valid_r <= rd_issue_s;
      if (rd_issue_s) rd_colour_r <= rd_oor_r ? 3'b000 : mem[rd_addr_r];
      if ((bus.plot && !in_range(bus.x, bus.y)) ||
          (rd_accept_s && !in_range(bus.rd_x, bus.rd_y)))
        oor_r <= 1'b1;
    end
  end

  assign bus.rd_ready  = rd_ready_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_colour = rd_colour_r;
  assign bus.clr_busy  = clr_busy_r;
  assign bus.oor       = oor_r;

endmodule

// File: tb/tb_plot_shadow_fb.sv
// Directed bench for plot_shadow_fb: vector table of plot+read pairs plus
// hand-written sequences for latency, stall, clear and reset corner cases.
module tb_plot_shadow_fb;

  logic clk;
  logic resetn;
  int   n_total;
  int   n_pass;

  plot_shadow_fb_if bus ();

  plot_shadow_fb #(.WIDTH(160), .HEIGHT(120), .DEPTH(19200)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_plot;
    logic [7:0] wx;
    logic [6:0] wy;
    logic [2:0] wc;
    logic [7:0] rx;
    logic [6:0] ry;
    logic [2:0] exp_colour;
    logic       exp_oor;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    bus.plot = 1'b1; bus.x = px; bus.y = py; bus.colour = pc;
    step();
    bus.plot = 1'b0;
  endtask

  // Read with no plots: accept now, valid two cycles later.
  task automatic do_read(input string name, input logic [7:0] rx, input logic [6:0] ry,
                         input logic [2:0] exp);
    check({name, "_ready"}, 32'(bus.rd_ready), 32'd1);
    bus.rd_req = 1'b1; bus.rd_x = rx; bus.rd_y = ry;
    step();
    bus.rd_req = 1'b0;
    step();
    check({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({name, "_colour"}, 32'(bus.rd_colour), 32'(exp));
    step();
  endtask

  int k;

  initial begin
    n_total = 0;
    n_pass  = 0;
    resetn = 1'b0;
    bus.plot = 1'b0; bus.x = 8'd0; bus.y = 7'd0; bus.colour = 3'b000;
    bus.rd_req = 1'b0; bus.rd_x = 8'd0; bus.rd_y = 7'd0; bus.clr_req = 1'b0;

    //                 plot  wx      wy      wc      rx      ry      exp     oor
    vecs[0] = '{1'b1, 8'd159, 7'd119, 3'd7, 8'd159, 7'd119, 3'd7, 1'b0};
    vecs[1] = '{1'b1, 8'd0,   7'd0,   3'd2, 8'd0,   7'd0,   3'd2, 1'b0};
    vecs[2] = '{1'b1, 8'd10,  7'd20,  3'd5, 8'd10,  7'd20,  3'd5, 1'b0};
    vecs[3] = '{1'b1, 8'd80,  7'd60,  3'd3, 8'd0,   7'd0,   3'd2, 1'b0};
    vecs[4] = '{1'b0, 8'd0,   7'd0,   3'd0, 8'd159, 7'd0,   3'd0, 1'b0};
    vecs[5] = '{1'b1, 8'd0,   7'd119, 3'd4, 8'd0,   7'd119, 3'd4, 1'b0};
    vecs[6] = '{1'b1, 8'd159, 7'd0,   3'd6, 8'd159, 7'd0,   3'd6, 1'b0};
    vecs[7] = '{1'b1, 8'd160, 7'd5,   3'd1, 8'd0,   7'd6,   3'd0, 1'b1};
    vecs[8] = '{1'b0, 8'd0,   7'd0,   3'd0, 8'd80,  7'd60,  3'd3, 1'b1};
    vecs[9] = '{1'b0, 8'd0,   7'd0,   3'd0, 8'd3,   7'd120, 3'd0, 1'b1};

    step();
    step();
    check("rst_rd_ready", 32'(bus.rd_ready), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_colour", 32'(bus.rd_colour), 32'd0);
    check("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    check("rst_oor", 32'(bus.oor), 32'd0);
    resetn = 1'b1;
    step();

    // Initial clear without plots: busy for exactly 19200 cycles.
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    k = 0;
    while (bus.clr_busy && k < 20000) begin
      check("clr0_ready_low", 32'(bus.rd_ready), 32'd0);
      k++;
      step();
    end
    check("clr0_busy_cycles", 32'(k), 32'd19200);
    check("clr0_ready_after", 32'(bus.rd_ready), 32'd1);

    // Table: plot and read accepted in the same cycle, latency 2.
    for (int i = 0; i < 10; i++) begin
      check($sformatf("v%0d_ready", i), 32'(bus.rd_ready), 32'd1);
      bus.plot = vecs[i].do_plot; bus.x = vecs[i].wx; bus.y = vecs[i].wy;
      bus.colour = vecs[i].wc;
      bus.rd_req = 1'b1; bus.rd_x = vecs[i].rx; bus.rd_y = vecs[i].ry;
      step();
      bus.plot = 1'b0; bus.rd_req = 1'b0;
      check($sformatf("v%0d_pend", i), 32'({bus.rd_valid, bus.rd_ready}), 32'd0);
      step();
      check($sformatf("v%0d_valid", i), 32'(bus.rd_valid), 32'd1);
      check($sformatf("v%0d_colour", i), 32'(bus.rd_colour), 32'(vecs[i].exp_colour));
      step();
      check($sformatf("v%0d_valid_drop", i), 32'(bus.rd_valid), 32'd0);
      check($sformatf("v%0d_oor", i), 32'(bus.oor), 32'(vecs[i].exp_oor));
    end

    // oor is sticky until reset.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("oor_after_reset", 32'(bus.oor), 32'd0);
    step();

    // Plot in cycle 0, read in cycle 1, rd_valid in cycle 3.
    bus.plot = 1'b1; bus.x = 8'd10; bus.y = 7'd20; bus.colour = 3'b101;
    step();
    bus.plot = 1'b0;
    bus.rd_req = 1'b1; bus.rd_x = 8'd10; bus.rd_y = 7'd20;
    step();
    bus.rd_req = 1'b0;
    check("seq1_c2_valid", 32'(bus.rd_valid), 32'd0);
    step();
    check("seq1_c3_valid", 32'(bus.rd_valid), 32'd1);
    check("seq1_colour", 32'(bus.rd_colour), 32'd5);
    step();
    check("seq1_ready_back", 32'(bus.rd_ready), 32'd1);

    // Read stall: five plot cycles push rd_valid to 7 cycles after accept.
    bus.rd_req = 1'b1; bus.rd_x = 8'd0; bus.rd_y = 7'd0;
    step();
    bus.rd_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      bus.plot = 1'b1; bus.x = 8'(50 + c); bus.y = 7'd50; bus.colour = 3'b001;
      check($sformatf("stall_c%0d", c), 32'({bus.rd_valid, bus.rd_ready}), 32'd0);
      step();
    end
    bus.plot = 1'b0;
    check("stall_c6", 32'({bus.rd_valid, bus.rd_ready}), 32'd0);
    step();
    check("stall_c7_valid", 32'(bus.rd_valid), 32'd1);
    check("stall_c7_ready", 32'(bus.rd_ready), 32'd0);
    check("stall_colour", 32'(bus.rd_colour), 32'd2);
    step();

    // Clear with corners filled and three interleaved plots.
    do_plot(8'd0, 7'd0, 3'd1);
    do_plot(8'd159, 7'd0, 3'd2);
    do_plot(8'd0, 7'd119, 3'd3);
    do_plot(8'd159, 7'd119, 3'd4);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    k = 0;
    while (bus.clr_busy && k < 20000) begin
      k++;
      bus.plot = 1'b0;
      if (k == 10)  begin bus.plot = 1'b1; bus.x = 8'd159; bus.y = 7'd119; bus.colour = 3'd5; end
      if (k == 100) begin bus.plot = 1'b1; bus.x = 8'd5;   bus.y = 7'd0;   bus.colour = 3'd6; end
      if (k == 500) begin bus.plot = 1'b1; bus.x = 8'd20;  bus.y = 7'd1;   bus.colour = 3'd3; end
      step();
    end
    bus.plot = 1'b0;
    check("clr_busy_cycles", 32'(k), 32'd19203);
    do_read("corner_00", 8'd0, 7'd0, 3'd0);
    do_read("corner_159_0", 8'd159, 7'd0, 3'd0);
    do_read("corner_0_119", 8'd0, 7'd119, 3'd0);
    do_read("corner_159_119", 8'd159, 7'd119, 3'd0);
    do_read("late_plot_5_0", 8'd5, 7'd0, 3'd6);
    do_read("late_plot_20_1", 8'd20, 7'd1, 3'd3);
    do_read("cleared_80_60", 8'd80, 7'd60, 3'd0);

    // Reset while a read is pending.
    bus.rd_req = 1'b1; bus.rd_x = 8'd5; bus.rd_y = 7'd0;
    step();
    bus.rd_req = 1'b0;
    bus.plot = 1'b1; bus.x = 8'd1; bus.y = 7'd1; bus.colour = 3'd1;
    resetn = 1'b0;
    step();
    bus.plot = 1'b0;
    resetn = 1'b1;
    check("rstrd_valid_in_reset", 32'(bus.rd_valid), 32'd0);
    step();
    check("rstrd_ready_after", 32'(bus.rd_ready), 32'd1);
    k = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rd_valid) k++;
      step();
    end
    check("rstrd_no_valid", 32'(k), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/plot_shadow_fb.md
# plot_shadow_fb

Shadow framebuffer that sits on the 160x120 plot bus (x, y, colour, plot) in parallel with the VGA adapter. It mirrors every plotted pixel into an on-chip 19200x3 single-port RAM and answers pixel-colour read requests from game logic over a request/ready/valid handshake, for collision and hit testing. It also provides a full-screen hardware clear to black.

## Interface
Parameters:
- WIDTH, 160: horizontal resolution in pixels.
- HEIGHT, 120: vertical resolution in pixels.
- DEPTH, 19200: RAM words, equal to WIDTH*HEIGHT.

Ports:
- clk  input  1  system clock (CLOCK_50); every register updates on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- plot  input  1  write strobe; one pixel is written per cycle when high.
- x  input  8  write column, 0..159.
- y  input  7  write row, 0..119.
- colour  input  3  write colour {R,G,B}.
- rd_req  input  1  read request; accepted only in a cycle where rd_ready is high.
- rd_x  input  8  read column; sampled on accept.
- rd_y  input  7  read row; sampled on accept.
- rd_ready  output  1  block can accept a read request this cycle.
- rd_valid  output  1  one-cycle pulse; rd_colour is valid in that cycle.
- rd_colour  output  3  pixel colour returned by the read.
- clr_req  input  1  starts a full-screen clear; accepted only in S_IDLE.
- clr_busy  output  1  high while a clear is in progress.
- oor  output  1  sticky flag; set by any out-of-range plot or read.

## Operation
- Address rule: addr = y*160 + x = {y,7'b0} + {y,5'b0} + x, computed at 15 bits. Maximum address is 19199.
- Range check: a coordinate is out of range when x >= 160 or y >= 119+1.
  - Out-of-range plot: the write is dropped and oor is set.
  - Out-of-range read: it is accepted, returns rd_colour = 0 on normal timing, and sets oor.
- Write priority: a plot with in-range coordinates always owns the RAM port in its cycle, in every state.
- States:
  - S_IDLE:
    - rd_ready = 1.
    - If clr_req is high, go to S_CLEAR; clr_req takes priority over a simultaneous rd_req.
    - Otherwise, if rd_req is high, capture rd_x and rd_y and go to S_RD_PEND.
  - S_RD_PEND:
    - rd_ready = 0.
    - If plot is low this cycle, issue the RAM read and go to S_RD_DATA.
    - Otherwise stay in S_RD_PEND, with no cycle limit.
  - S_RD_DATA:
    - rd_ready = 0.
    - Registered RAM output is driven onto rd_colour, rd_valid = 1, then go to S_IDLE.
  - S_CLEAR:
    - rd_ready = 0 and clr_busy = 1.
    - A 15-bit counter writes 3'b000 at address cnt on every cycle without a plot.
    - The counter advances only on those writes and holds during plot cycles.
    - After the write at address 19199, the counter returns to 0 and the block goes to S_IDLE.
- Plot during clear: the plot is written. If its address is at or above the clear counter, it is later overwritten with black, which is intended.
- clr_req and rd_req in any state other than S_IDLE are ignored; requesters hold them until they are accepted.
- oor clears only on reset.
- The RAM contents are not cleared by reset; software issues clr_req after reset.

## Timing
Reset values: state S_IDLE, rd_ready 1, rd_valid 0, rd_colour 0, clr_busy 0, oor 0, clear counter 0, captured read address 0.

Read latency:
- Accept in cycle T, with no plots: RAM read in T+1, rd_valid in T+2. This is the minimum latency of 2.
- Each cycle in S_RD_PEND with plot high adds 1 cycle.
- rd_ready returns high in the cycle after rd_valid. Back-to-back reads therefore run at one per 3 cycles.

Read-after-write: a plot in cycle T is visible to any RAM read issued in T+1 or later. A read accepted in the same cycle T as a plot returns the new value.

Clear:
- Accept in T: clr_busy is high from T+1. Writes occupy T+1..T+19200 when no plots occur.
- clr_busy falls and rd_ready rises at T+19201. Each interleaved plot extends this by 1 cycle.

Reset mid-operation: a pending read is abandoned with no rd_valid, and a clear is abandoned with the RAM partially cleared. All outputs return to their reset values on the next edge.

## Test plan
- Single write and read: plot (10,20,3'b101) in cycle 0, then read (10,20) in cycle 1. Required: rd_valid in cycle 3, rd_colour 3'b101.
- Write and read in the same cycle: plot (159,119,3'b111) and read (159,119) both in cycle 0. Required: rd_colour 3'b111 with rd_valid in cycle 2, confirming address 19199.
- Read stall: accept read (0,0), then hold plot high for 5 cycles at other addresses. Required: rd_valid arrives exactly 7 cycles after accept, and rd_ready stays 0 throughout.
- Clear:
  - Fill the corners, pulse clr_req, and inject 3 plots mid-clear. Required: clr_busy high for exactly 19203 cycles.
  - Read all four corners afterwards. Required: each returns 0.
  - Plots made after the counter passed their address keep their colour.
- Out of range:
  - Plot (160,5,3'b001). Required: no RAM change and oor = 1.
  - Read (3,120). Required: rd_colour 0 at latency 2.
  - Reset. Required: oor = 0.
- Reset mid-read: assert resetn = 0 in S_RD_PEND. Required: rd_valid never pulses, and rd_ready is 1 on the cycle after reset deasserts.
